mathbox_seq: RTL
================

Name: mathbox_seq

Overview:
- Microsequencer that drives the 8-bit address into the 256x4 registered microcode PROMs of the mathbox.
- Consumes their nibble outputs: one control nibble, plus two nibbles that together form a jump target.
- Sequence of operation: the CPU writes a command index; the block looks up the start address in a registered start-map PROM, then steps the microprogram until a STOP bit.
- Per step, it emits a one-cycle valid strobe to the downstream ALU/register stage.

Parameters:
- ADDR_W, 8, microcode address width (PROM depth 2^ADDR_W).
- CMD_W, 5, CPU command index width (32 entry points).
- MAX_STEPS, 255, watchdog limit on executed microinstructions per command.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state advances only when high
- cmd_wr  in  1  CPU write strobe, one clk wide, qualified by cen
- cmd_idx  in  CMD_W  command index captured on cmd_wr
- map_addr  out  CMD_W  address to start-map PROM
- map_data  in  ADDR_W  start-map PROM data, valid one cen-cycle after map_addr
- rom_addr  out  ADDR_W  microcode PROM address (program counter)
- rom_cs  out  1  microcode PROM select
- ctl_nib  in  4  control nibble: [0] STOP, [1] JMP, [2] CONDSEL, [3] passthrough
- jmp_hi  in  4  jump target bits [7:4]
- jmp_lo  in  4  jump target bits [3:0]
- cond_in  in  1  ALU condition (sign) from downstream, sampled in EXEC
- uop_valid  out  1  one-cycle strobe: microcode nibbles valid for current step
- busy  out  1  status readable by CPU
- overrun  out  1  sticky: cmd_wr arrived while busy
- wdog_err  out  1  sticky: MAX_STEPS reached without STOP

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=IDLE; rom_addr=0, map_addr=0.
  - rom_cs, uop_valid, busy, overrun and wdog_err all 0.
  - Step counter cleared.
- When cen is low, state, outputs and counter all hold; uop_valid is forced 0.
- IDLE:
  - cmd_wr → latch cmd_idx into map_addr; busy=1; clear overrun and wdog_err; go to MAP.
- MAP: wait one cen-cycle for the registered PROM; go to LOAD.
- LOAD: rom_addr<=map_data; rom_cs=1; step counter<=0; go to FETCH.
- FETCH: rom_addr stable at the PROMs; go to EXEC.
- EXEC (nibbles valid):
  - uop_valid=1 for this one cen-cycle; step counter +1.
  - STOP=1: go to IDLE; busy=0 and rom_cs=0 on the next cycle. STOP has priority over JMP.
  - Else if JMP=1 and (CONDSEL=0 or cond_in=1): rom_addr<={jmp_hi,jmp_lo}.
  - Else rom_addr<=rom_addr+1, modulo 2^ADDR_W (0xFF wraps to 0x00).
  - If the new step count equals MAX_STEPS and STOP=0: set wdog_err; go to IDLE; busy=0.
  - Otherwise go to FETCH.
- Throughput: 2 cen-cycles per microinstruction.
- Latency: cmd_wr to first uop_valid = 4 cen-cycles (MAP, LOAD, FETCH, EXEC).
- cmd_wr in any state other than IDLE: ignored and overrun set. A cmd_wr in the same cycle EXEC returns to IDLE is also ignored.
- cond_in is sampled only in EXEC and ignored elsewhere.
- ctl_nib[3] has no effect on sequencing.
- Reset mid-program: abort immediately to the reset values; no uop_valid is emitted.

Decomposition:
- Shared package mathbox_pkg holds:
  - state enum {IDLE, MAP, LOAD, FETCH, EXEC};
  - ctl bit-index constants CTL_STOP=0, CTL_JMP=1, CTL_CONDSEL=2;
  - ADDR_W and CMD_W defaults.
- One sub-module, mathbox_step_wdog: loadable step counter with a terminal-count flag. Everything else sits in a single FSM body.

Test Plan:
- Straight line: cmd_idx=3, map_data=0x10; ctl_nib=0 at 0x10..0x12, STOP at 0x13 → uop_valid at rom_addr 0x10,0x11,0x12,0x13; busy falls the cycle after the 0x13 EXEC; first uop_valid 4 cycles after cmd_wr.
- Jumps: ctl_nib=0b0010 at 0x20 with jmp=0x5A → next rom_addr=0x5A. ctl_nib=0b0110 with cond_in=0 → 0x21; with cond_in=1 → 0x5A.
- Wrap-around: start 0xFE, no STOP/JMP until 0x01 → addresses 0xFE,0xFF,0x00,0x01.
- Watchdog: MAX_STEPS=4, no STOP → exactly 4 uop_valid pulses, then wdog_err=1, busy=0; the next cmd_wr clears wdog_err.
- Overrun and cen: cmd_wr during FETCH → overrun=1 and program unchanged. Hold cen low 5 cycles mid-program → no state change, no uop_valid.
- Reset mid-EXEC: assert reset_n low → busy, rom_cs, uop_valid = 0 asynchronously; rom_addr=0.

Source files
------------

// File: rtl/mathbox_pkg.sv
`default_nettype none
// ============================================================================
// Module : mathbox_pkg
// Brief  : Shared types and constants for the mathbox microsequencer.
// Rev    : 1.0
// ============================================================================
package mathbox_pkg;

  localparam int MB_ADDR_W = 8;
  localparam int MB_CMD_W  = 5;

  localparam int CTL_STOP    = 0;
  localparam int CTL_JMP     = 1;
  localparam int CTL_CONDSEL = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAP   = 3'd1,
    LOAD  = 3'd2,
    FETCH = 3'd3,
    EXEC  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mathbox_step_wdog.sv
`default_nettype none
// ============================================================================
// Module : mathbox_step_wdog
// Brief  : Loadable step counter; flags when the next increment hits MAX_STEPS.
// Rev    : 1.0
// ============================================================================
module mathbox_step_wdog #(
  parameter int MAX_STEPS = 255,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cen,
  input  logic clr,
  input  logic inc,
  output logic tc_next
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(MAX_STEPS - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (cen) begin
      if (clr) begin
        r_cnt <= '0;
      end else if (inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // High while the step in progress would be the MAX_STEPS-th one
  assign tc_next = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/mathbox_seq.sv
`default_nettype none
// ============================================================================
// Module : mathbox_seq
// Brief  : Mathbox microsequencer: start-map lookup, PROM stepping, watchdog.
// Rev    : 1.0
// ============================================================================
module mathbox_seq
  import mathbox_pkg::*;
#(
  parameter int ADDR_W    = MB_ADDR_W,
  parameter int CMD_W     = MB_CMD_W,
  parameter int MAX_STEPS = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cen,
  input  logic              cmd_wr,
  input  logic [CMD_W-1:0]  cmd_idx,
  output logic [CMD_W-1:0]  map_addr,
  input  logic [ADDR_W-1:0] map_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_cs,
  input  logic [3:0]        ctl_nib,
  input  logic [3:0]        jmp_hi,
  input  logic [3:0]        jmp_lo,
  input  logic              cond_in,
  output logic              uop_valid,
  output logic              busy,
  output logic              overrun,
  output logic              wdog_err
);

  localparam int c_cnt_w = $clog2(MAX_STEPS + 1);

  state_t            r_state, w_state_nxt;
  logic [CMD_W-1:0]  r_map_addr, w_map_addr_nxt;
  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_nxt;
  logic              r_rom_cs, w_rom_cs_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic              r_wdog_err, w_wdog_err_nxt;
  logic              w_cnt_clr, w_cnt_inc, w_tc;
  logic [ADDR_W-1:0] w_jmp_tgt;
  logic              w_unused_ctl;

  assign w_jmp_tgt    = ADDR_W'({jmp_hi, jmp_lo});
  assign w_unused_ctl = ctl_nib[3];

  mathbox_step_wdog #(
    .MAX_STEPS (MAX_STEPS),
    .CNT_W     (c_cnt_w)
  ) u_step_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .cen     (cen),
    .clr     (w_cnt_clr),
    .inc     (w_cnt_inc),
    .tc_next (w_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_map_addr <= '0;
      r_rom_addr <= '0;
      r_rom_cs   <= 1'b0;
      r_overrun  <= 1'b0;
      r_wdog_err <= 1'b0;
    end else if (cen) begin
      r_state    <= w_state_nxt;
      r_map_addr <= w_map_addr_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_rom_cs   <= w_rom_cs_nxt;
      r_overrun  <= w_overrun_nxt;
      r_wdog_err <= w_wdog_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_map_addr_nxt = r_map_addr;
    w_rom_addr_nxt = r_rom_addr;
    w_rom_cs_nxt   = r_rom_cs;
    w_overrun_nxt  = r_overrun;
    w_wdog_err_nxt = r_wdog_err;
    w_cnt_clr      = 1'b0;
    w_cnt_inc      = 1'b0;

    // Any write outside IDLE is dropped, including the EXEC that returns to IDLE
    if (cmd_wr && (r_state != IDLE)) begin
      w_overrun_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (cmd_wr) begin
          w_map_addr_nxt = cmd_idx;
          w_overrun_nxt  = 1'b0;
          w_wdog_err_nxt = 1'b0;
          w_state_nxt    = MAP;
        end
      end
      MAP: begin
        w_state_nxt = LOAD;
      end
      LOAD: begin
        w_rom_addr_nxt = map_data;
        w_rom_cs_nxt   = 1'b1;
        w_cnt_clr      = 1'b1;
        w_state_nxt    = FETCH;
      end
      FETCH: begin
        w_state_nxt = EXEC;
      end
      EXEC: begin
        w_cnt_inc = 1'b1;
        if (ctl_nib[CTL_STOP]) begin
          w_rom_cs_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end else begin
          if (ctl_nib[CTL_JMP] && (!ctl_nib[CTL_CONDSEL] || cond_in)) begin
            w_rom_addr_nxt = w_jmp_tgt;
          end else begin
            w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
          end
          if (w_tc) begin
            w_wdog_err_nxt = 1'b1;
            w_rom_cs_nxt   = 1'b0;
            w_state_nxt    = IDLE;
          end else begin
            w_state_nxt = FETCH;
          end
        end
      end
      default: begin
        w_rom_cs_nxt = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  assign map_addr  = r_map_addr;
  assign rom_addr  = r_rom_addr;
  assign rom_cs    = r_rom_cs;
  assign uop_valid = cen && (r_state == EXEC);
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;
  assign wdog_err  = r_wdog_err;

endmodule
`default_nettype wire
